// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Signal bundle between the pipeline datapath and the hazard
//                controller. The "master" side is the pipeline: it reports
//                ID/EX/MEM stage information and consumes the control
//                outputs. The "slave" side is hazard_ctrl.
//  Signals     : id_Rs1/id_Rs2/id_uses_rs1/id_uses_rs2 - ID operand usage
//                ex_memRead/ex_regToWrite              - load in EX
//                mem_branch_taken                      - MEM branch redirect
//                dmem_req/dmem_ready                   - data-memory handshake
//                pc_write/if_id_write/if_id_flush/doNOP/ex_mem_flush/
//                pipe_hold                             - pipeline control
//                mem_timeout/stall_cnt/flush_cnt       - status and counters
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int CNT_BITWIDTH     = 16
);
   logic [REG_NUM_BITWIDTH-1:0] id_Rs1;
   logic [REG_NUM_BITWIDTH-1:0] id_Rs2;
   logic                        id_uses_rs1;
   logic                        id_uses_rs2;
   logic                        ex_memRead;
   logic [REG_NUM_BITWIDTH-1:0] ex_regToWrite;
   logic                        mem_branch_taken;
   logic                        dmem_req;
   logic                        dmem_ready;
   logic                        pc_write;
   logic                        if_id_write;
   logic                        if_id_flush;
   logic                        doNOP;
   logic                        ex_mem_flush;
   logic                        pipe_hold;
   logic                        mem_timeout;
   logic [CNT_BITWIDTH-1:0]     stall_cnt;
   logic [CNT_BITWIDTH-1:0]     flush_cnt;

   modport master (
      output id_Rs1, id_Rs2, id_uses_rs1, id_uses_rs2,
      output ex_memRead, ex_regToWrite, mem_branch_taken,
      output dmem_req, dmem_ready,
      input  pc_write, if_id_write, if_id_flush, doNOP, ex_mem_flush,
      input  pipe_hold, mem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_Rs1, id_Rs2, id_uses_rs1, id_uses_rs2,
      input  ex_memRead, ex_regToWrite, mem_branch_taken,
      input  dmem_req, dmem_ready,
      output pc_write, if_id_write, if_id_flush, doNOP, ex_mem_flush,
      output pipe_hold, mem_timeout, stall_cnt, flush_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard and stall controller. Handles load-use
//                bubbles, taken-branch redirects with a multi-cycle IF/ID
//                flush window, data-memory wait states with a sticky timeout
//                flag, and saturating stall/flush performance counters.
//                Control outputs are combinational from state plus inputs.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                bus   - hazard_ctrl_if.slave (pipeline status in, control
//                        and counters out)
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int REG_NUM_BITWIDTH = 5,
   parameter int FLUSH_CYCLES     = 2,
   parameter int MAX_WAIT         = 64,
   parameter int CNT_BITWIDTH     = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  bus
);

   localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int WC_W = $clog2(MAX_WAIT + 1);
   localparam logic [FL_W-1:0] FL_RELOAD  = FL_W'(FLUSH_CYCLES - 1);
   localparam logic [WC_W-1:0] WAIT_LIMIT = WC_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      FLUSH   = 2'd1,
      MEMWAIT = 2'd2
   } state_t;

   state_t                      r_state, w_state_nxt, w_eff_state;
   logic [FL_W-1:0]             r_flush_left, w_flush_left_nxt;
   logic [WC_W-1:0]             r_wait_cnt, w_wait_cnt_nxt;
   logic                        r_mem_timeout, w_mem_timeout_nxt;
   logic [CNT_BITWIDTH-1:0]     r_stall_cnt, r_flush_cnt;

   logic [REG_NUM_BITWIDTH-1:0] w_rs1, w_rs2, w_rd;
   logic                        w_mem_stall, w_lu_hazard, w_branch;
   logic                        w_pc_write, w_if_id_write, w_if_id_flush;
   logic                        w_do_nop, w_ex_mem_flush, w_pipe_hold;

   assign w_rs1 = bus.id_Rs1;
   assign w_rs2 = bus.id_Rs2;
   assign w_rd  = bus.ex_regToWrite;

   assign w_mem_stall = bus.dmem_req & ~bus.dmem_ready;
   // r0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign w_lu_hazard = bus.ex_memRead && (w_rd != '0) &&
                        ((bus.id_uses_rs1 && (w_rs1 == w_rd)) ||
                         (bus.id_uses_rs2 && (w_rs2 == w_rd)));

   // Next-state and control outputs, highest priority first.
   always_comb begin
      w_pc_write        = 1'b1;
      w_if_id_write     = 1'b1;
      w_if_id_flush     = 1'b0;
      w_do_nop          = 1'b0;
      w_ex_mem_flush    = 1'b0;
      w_pipe_hold       = 1'b0;
      w_branch          = 1'b0;
      // Leaving MEMWAIT resumes whatever the stall interrupted: a pending
      // flush window (flush_left held non-zero) or normal running.
      w_eff_state       = r_state;
      if (r_state == MEMWAIT)
         w_eff_state = (r_flush_left != '0) ? FLUSH : RUN;
      w_state_nxt       = w_eff_state;
      w_flush_left_nxt  = r_flush_left;
      w_wait_cnt_nxt    = '0;
      w_mem_timeout_nxt = r_mem_timeout;

      if (w_mem_stall) begin
         w_pc_write     = 1'b0;
         w_if_id_write  = 1'b0;
         w_pipe_hold    = 1'b1;
         w_state_nxt    = MEMWAIT;
         w_wait_cnt_nxt = (r_wait_cnt != WAIT_LIMIT) ? r_wait_cnt + WC_W'(1) : r_wait_cnt;
         if (w_wait_cnt_nxt == WAIT_LIMIT)
            w_mem_timeout_nxt = 1'b1;
      end else if (bus.mem_branch_taken) begin
         w_branch       = 1'b1;
         w_if_id_flush  = 1'b1;
         w_do_nop       = 1'b1;
         w_ex_mem_flush = 1'b1;
         if (FLUSH_CYCLES > 1) begin
            w_state_nxt      = FLUSH;
            w_flush_left_nxt = FL_RELOAD;
         end else begin
            w_state_nxt      = RUN;
            w_flush_left_nxt = '0;
         end
      end else if (w_eff_state == FLUSH) begin
         w_if_id_flush    = 1'b1;
         w_do_nop         = 1'b1;
         w_flush_left_nxt = r_flush_left - FL_W'(1);
         w_state_nxt      = (r_flush_left == FL_W'(1)) ? RUN : FLUSH;
      end else if (w_lu_hazard) begin
         w_pc_write    = 1'b0;
         w_if_id_write = 1'b0;
         w_do_nop      = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= RUN;
         r_flush_left  <= '0;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
         r_stall_cnt   <= '0;
         r_flush_cnt   <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_flush_left  <= w_flush_left_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_mem_timeout <= w_mem_timeout_nxt;
         if (!w_pc_write && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_BITWIDTH'(1);
         if (w_branch && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_BITWIDTH'(1);
      end
   end

   assign bus.pc_write     = w_pc_write;
   assign bus.if_id_write  = w_if_id_write;
   assign bus.if_id_flush  = w_if_id_flush;
   assign bus.doNOP        = w_do_nop;
   assign bus.ex_mem_flush = w_ex_mem_flush;
   assign bus.pipe_hold    = w_pipe_hold;
   assign bus.mem_timeout  = r_mem_timeout;
   assign bus.stall_cnt    = r_stall_cnt;
   assign bus.flush_cnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl: directed vector table,
//                hand-written timeout / asynchronous-reset sequences and a
//                randomized run against a behavioural model.
//                Control bits are compared packed as
//                {pc_write, if_id_write, if_id_flush, doNOP, ex_mem_flush,
//                 pipe_hold}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
   localparam int RW = 5;
   localparam int FC = 2;
   localparam int MW = 4;
   localparam int CW = 6;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_NUM_BITWIDTH(RW), .CNT_BITWIDTH(CW)) bus ();

   hazard_ctrl #(
      .REG_NUM_BITWIDTH(RW),
      .FLUSH_CYCLES    (FC),
      .MAX_WAIT        (MW),
      .CNT_BITWIDTH    (CW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   typedef struct {
      logic [RW-1:0] rs1;
      logic          u1;
      logic [RW-1:0] rs2;
      logic          u2;
      logic          mr;
      logic [RW-1:0] rd;
      logic          br;
      logic          req;
      logic          rdy;
      logic [5:0]    ctl;
      int            st;
      int            fl;
      logic          to;
   } vec_t;

   localparam logic [5:0] C_DEF  = 6'b110000;
   localparam logic [5:0] C_LU   = 6'b000100;
   localparam logic [5:0] C_BR   = 6'b111110;
   localparam logic [5:0] C_FL   = 6'b111100;
   localparam logic [5:0] C_MEM  = 6'b000001;

   int checks = 0;
   int errors = 0;

   // Behavioural model: a flush window is just a count of remaining flush
   // cycles, a memory wait is a count of consecutive stalled cycles.
   int m_flush_left, m_wait, m_stall_cnt, m_flush_cnt;
   bit m_timeout;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [5:0] dut_ctl();
      return {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.doNOP, bus.ex_mem_flush, bus.pipe_hold};
   endfunction

   task automatic set_in(logic [RW-1:0] rs1, logic u1, logic [RW-1:0] rs2, logic u2,
                         logic mr, logic [RW-1:0] rd, logic br, logic req, logic rdy);
      bus.id_Rs1 = rs1;  bus.id_uses_rs1 = u1;
      bus.id_Rs2 = rs2;  bus.id_uses_rs2 = u2;
      bus.ex_memRead = mr;  bus.ex_regToWrite = rd;
      bus.mem_branch_taken = br;
      bus.dmem_req = req;  bus.dmem_ready = rdy;
   endtask

   task automatic set_idle();
      set_in('0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic model_reset();
      m_flush_left = 0; m_wait = 0; m_stall_cnt = 0; m_flush_cnt = 0; m_timeout = 0;
   endtask

   function automatic logic [5:0] model_ctl();
      bit stall, lu;
      stall = bus.dmem_req && !bus.dmem_ready;
      lu = bus.ex_memRead && (bus.ex_regToWrite != 0) &&
           ((bus.id_uses_rs1 && bus.id_Rs1 == bus.ex_regToWrite) ||
            (bus.id_uses_rs2 && bus.id_Rs2 == bus.ex_regToWrite));
      if (stall)                    return C_MEM;
      else if (bus.mem_branch_taken) return C_BR;
      else if (m_flush_left > 0)    return C_FL;
      else if (lu)                  return C_LU;
      else                          return C_DEF;
   endfunction

   task automatic model_edge(logic [5:0] ctl);
      if (bus.dmem_req && !bus.dmem_ready) begin
         if (m_wait < MW) m_wait++;
         if (m_wait >= MW) m_timeout = 1;
      end else begin
         m_wait = 0;
         if (bus.mem_branch_taken) begin
            m_flush_left = FC - 1;
            if (m_flush_cnt < CMAX) m_flush_cnt++;
         end else if (m_flush_left > 0) begin
            m_flush_left--;
         end
      end
      if (!ctl[5] && m_stall_cnt < CMAX) m_stall_cnt++;
   endtask

   // Called just after a rising edge; leaves the bench just after the next.
   task automatic do_reset();
      set_idle();
      rst_n = 1'b0;
      #2;
      model_reset();
      chk("rst_ctl", int'(dut_ctl()), int'(C_DEF));
      chk("rst_stall_cnt", int'(bus.stall_cnt), 0);
      chk("rst_flush_cnt", int'(bus.flush_cnt), 0);
      chk("rst_timeout", int'(bus.mem_timeout), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   vec_t tbl[23];

   function automatic vec_t v(logic [RW-1:0] rs1, logic u1, logic [RW-1:0] rs2, logic u2,
                              logic mr, logic [RW-1:0] rd, logic br, logic req, logic rdy,
                              logic [5:0] ctl, int st, int fl, logic to);
      vec_t r;
      r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2; r.mr = mr; r.rd = rd;
      r.br = br; r.req = req; r.rdy = rdy; r.ctl = ctl; r.st = st; r.fl = fl; r.to = to;
      return r;
   endfunction

   initial begin
      logic [5:0] e;
      // Directed sequence from reset; counters are the values seen before
      // each row's clock edge.
      tbl[0]  = v(0,0,0,0, 0,0, 0,0,0, C_DEF, 0,0,0);
      tbl[1]  = v(0,0,5,1, 1,5, 0,0,0, C_LU,  0,0,0);  // load-use on rs2
      tbl[2]  = v(0,0,5,1, 0,5, 0,0,0, C_DEF, 1,0,0);  // bubble cleared load
      tbl[3]  = v(0,1,0,0, 1,0, 0,0,0, C_DEF, 1,0,0);  // r0 never stalls
      tbl[4]  = v(7,0,3,1, 1,7, 0,0,0, C_DEF, 1,0,0);  // rs1 match but unused
      tbl[5]  = v(0,0,0,0, 0,0, 1,0,0, C_BR,  1,0,0);  // taken branch
      tbl[6]  = v(0,0,0,0, 0,0, 0,0,0, C_FL,  1,1,0);  // flush cycle 1
      tbl[7]  = v(0,0,0,0, 0,0, 0,0,0, C_DEF, 1,1,0);  // back to RUN
      tbl[8]  = v(0,0,0,0, 0,0, 1,0,0, C_BR,  1,1,0);
      tbl[9]  = v(0,0,0,0, 0,0, 0,1,0, C_MEM, 1,2,0);  // wait inside flush
      tbl[10] = v(0,0,0,0, 0,0, 0,1,0, C_MEM, 2,2,0);
      tbl[11] = v(0,0,0,0, 0,0, 0,1,0, C_MEM, 3,2,0);
      tbl[12] = v(0,0,0,0, 0,0, 0,1,1, C_FL,  4,2,0);  // remaining flush cycle
      tbl[13] = v(0,0,0,0, 0,0, 0,0,0, C_DEF, 4,2,0);
      tbl[14] = v(0,0,5,1, 1,5, 1,0,0, C_BR,  4,2,0);  // branch beats load-use
      tbl[15] = v(0,0,5,1, 1,5, 0,0,0, C_FL,  4,3,0);  // flush beats load-use
      tbl[16] = v(0,0,5,1, 1,5, 0,0,0, C_LU,  4,3,0);
      tbl[17] = v(0,0,0,0, 0,0, 0,0,0, C_DEF, 5,3,0);
      tbl[18] = v(0,0,0,0, 0,0, 1,1,0, C_MEM, 5,3,0);  // stall beats branch
      tbl[19] = v(0,0,0,0, 0,0, 0,0,0, C_DEF, 6,3,0);  // ignored branch: no flush
      tbl[20] = v(5,1,0,0, 1,5, 0,1,0, C_MEM, 6,3,0);  // stall beats load-use
      tbl[21] = v(5,1,0,0, 1,5, 0,0,0, C_LU,  7,3,0);
      tbl[22] = v(0,0,0,0, 0,0, 0,0,0, C_DEF, 8,3,0);

      // Reset state, checked while rst_n is still low.
      set_idle();
      model_reset();
      #3;
      chk("reset_ctl", int'(dut_ctl()), int'(C_DEF));
      chk("reset_stall_cnt", int'(bus.stall_cnt), 0);
      chk("reset_flush_cnt", int'(bus.flush_cnt), 0);
      chk("reset_timeout", int'(bus.mem_timeout), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 23; i++) begin
         set_in(tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].mr, tbl[i].rd,
                tbl[i].br, tbl[i].req, tbl[i].rdy);
         #3;
         chk($sformatf("vec%0d_ctl", i), int'(dut_ctl()), int'(tbl[i].ctl));
         chk($sformatf("vec%0d_stall_cnt", i), int'(bus.stall_cnt), tbl[i].st);
         chk($sformatf("vec%0d_flush_cnt", i), int'(bus.flush_cnt), tbl[i].fl);
         chk($sformatf("vec%0d_timeout", i), int'(bus.mem_timeout), int'(tbl[i].to));
         @(posedge clk); #1;
      end

      // Timeout: four consecutive stalled cycles with MAX_WAIT=4.
      do_reset();
      set_in('0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #3;
         chk($sformatf("to_wait%0d_timeout", i), int'(bus.mem_timeout), 0);
         chk($sformatf("to_wait%0d_ctl", i), int'(dut_ctl()), int'(C_MEM));
         @(posedge clk); #1;
      end
      #3;
      chk("to_after4_timeout", int'(bus.mem_timeout), 1);
      @(posedge clk); #1;
      set_idle();
      #3;
      chk("to_ready_ctl", int'(dut_ctl()), int'(C_DEF));
      chk("to_ready_timeout", int'(bus.mem_timeout), 1);
      chk("to_stall_cnt", int'(bus.stall_cnt), 5);
      @(posedge clk); #1;
      chk("to_sticky", int'(bus.mem_timeout), 1);

      // Asynchronous reset in the middle of a wait inside a flush window.
      set_in('0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      set_in('0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #2;
      chk("ar_pre_flush_cnt", int'(bus.flush_cnt), 1);
      rst_n = 1'b0;
      #1;
      chk("ar_timeout", int'(bus.mem_timeout), 0);
      chk("ar_stall_cnt", int'(bus.stall_cnt), 0);
      chk("ar_flush_cnt", int'(bus.flush_cnt), 0);
      set_idle();
      #1;
      chk("ar_ctl_idle", int'(dut_ctl()), int'(C_DEF));
      rst_n = 1'b1;
      @(posedge clk); #3;
      chk("ar_no_resumed_flush", int'(dut_ctl()), int'(C_DEF));
      @(posedge clk); #1;

      // Randomized run against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if (n > 0 && $urandom_range(0, 399) == 0) begin
            do_reset();
         end
         set_in(RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                RW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), RW'($urandom_range(0, 3)),
                ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0));
         #3;
         e = model_ctl();
         chk("rand_ctl", int'(dut_ctl()), int'(e));
         chk("rand_stall_cnt", int'(bus.stall_cnt), m_stall_cnt);
         chk("rand_flush_cnt", int'(bus.flush_cnt), m_flush_cnt);
         chk("rand_timeout", int'(bus.mem_timeout), int'(m_timeout));
         model_edge(e);
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
